// File: rtl/pd_power_ctrl_if.sv
// Signal bundle between the PMU/power-switch side and the power-domain sequencer.
// The master drives requests and the switch acknowledge; the slave drives the domain controls.
interface pd_power_ctrl_if;
    logic       pwr_up_req;
    logic       pwr_down_req;
    logic       psw_ack;
    logic       pwr_on;
    logic       iso_en;
    logic       save;
    logic       restore;
    logic       dom_rst_n;
    logic [2:0] state;
    logic       busy;
    logic       done;
    logic       timeout_err;

    modport master (
        output pwr_up_req, pwr_down_req, psw_ack,
        input  pwr_on, iso_en, save, restore, dom_rst_n, state, busy, done, timeout_err
    );

    modport slave (
        input  pwr_up_req, pwr_down_req, psw_ack,
        output pwr_on, iso_en, save, restore, dom_rst_n, state, busy, done, timeout_err
    );
endinterface

// File: rtl/pd_power_ctrl.sv
// Power-domain sequencer: orders isolation, retention save/restore, switch enable and
// domain reset for one switchable domain, with a shared timeout on the switch acknowledge.
module pd_power_ctrl #(
    parameter int ISO_DLY     = 2,
    parameter int RST_DLY     = 3,
    parameter int PSW_TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pd_power_ctrl_if.slave bus
);
    localparam int MAX_A   = (ISO_DLY > RST_DLY) ? ISO_DLY : RST_DLY;
    localparam int MAX_DLY = (MAX_A > PSW_TIMEOUT) ? MAX_A : PSW_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_DLY) + 1;

    // Counter counts down to zero, so a phase lasting N cycles is loaded with N-1.
    localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_DLY - 1);
    localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_DLY - 1);
    localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(PSW_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_ON      = 3'd0,
        S_ISO     = 3'd1,
        S_SAVE    = 3'd2,
        S_PD      = 3'd3,
        S_OFF     = 3'd4,
        S_PU      = 3'd5,
        S_RST     = 3'd6,
        S_RESTORE = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
    logic             pwr_on_q, pwr_on_d;
    logic             iso_en_q, iso_en_d;
    logic             dom_rst_n_q, dom_rst_n_d;
    logic             save_q, save_d;
    logic             restore_q, restore_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;

        unique case (state_q)
            S_ON: begin
                if (bus.pwr_down_req) begin
                    state_d = S_ISO;
                    cnt_d   = ISO_LD;
                    terr_d  = 1'b0;
                end
            end
            S_ISO: begin
                if (cnt_zero) state_d = S_SAVE;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            S_SAVE: begin
                state_d = S_PD;
                cnt_d   = TO_LD;
            end
            S_PD: begin
                if (!bus.psw_ack) begin
                    state_d = S_OFF;
                end else if (cnt_zero) begin
                    state_d = S_OFF;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_OFF: begin
                if (bus.pwr_up_req) begin
                    state_d = S_PU;
                    cnt_d   = TO_LD;
                    terr_d  = 1'b0;
                end
            end
            S_PU: begin
                if (bus.psw_ack) begin
                    state_d = S_RST;
                    cnt_d   = RST_LD;
                end else if (cnt_zero) begin
                    // Rail never came up: switch it off again and settle in OFF.
                    state_d = S_PD;
                    cnt_d   = TO_LD;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RST: begin
                if (cnt_zero) state_d = S_RESTORE;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RESTORE: state_d = S_ON;
            default:   state_d = S_OFF;
        endcase

        // Outputs decode the next state so they register on the same edge as the state.
        {pwr_on_d, iso_en_d, dom_rst_n_d, save_d, restore_d} = 5'b01000;
        unique case (state_d)
            S_ON:      {pwr_on_d, iso_en_d, dom_rst_n_d, save_d, restore_d} = 5'b10100;
            S_ISO:     {pwr_on_d, iso_en_d, dom_rst_n_d, save_d, restore_d} = 5'b11100;
            S_SAVE:    {pwr_on_d, iso_en_d, dom_rst_n_d, save_d, restore_d} = 5'b11110;
            S_PU,
            S_RST:     {pwr_on_d, iso_en_d, dom_rst_n_d, save_d, restore_d} = 5'b11000;
            S_RESTORE: {pwr_on_d, iso_en_d, dom_rst_n_d, save_d, restore_d} = 5'b11101;
            default:   {pwr_on_d, iso_en_d, dom_rst_n_d, save_d, restore_d} = 5'b01000;
        endcase

        busy_d = (state_d != S_ON) && (state_d != S_OFF);
        done_d = (state_d != state_q) && !busy_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            terr_q      <= 1'b0;
            pwr_on_q    <= 1'b0;
            iso_en_q    <= 1'b1;
            dom_rst_n_q <= 1'b0;
            save_q      <= 1'b0;
            restore_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            terr_q      <= terr_d;
            pwr_on_q    <= pwr_on_d;
            iso_en_q    <= iso_en_d;
            dom_rst_n_q <= dom_rst_n_d;
            save_q      <= save_d;
            restore_q   <= restore_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.pwr_on      = pwr_on_q;
    assign bus.iso_en      = iso_en_q;
    assign bus.dom_rst_n   = dom_rst_n_q;
    assign bus.save        = save_q;
    assign bus.restore     = restore_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_err_w();

    function automatic logic timeout_err_w();
        return terr_q;
    endfunction
endmodule

// File: tb/tb_pd_power_ctrl.sv
// Scoreboard bench for pd_power_ctrl: transactions push the expected outcome, a monitor
// pops on every done pulse; a simple power-switch model answers pwr_on with a set latency.
module tb_pd_power_ctrl;
    localparam int ISO_DLY     = 2;
    localparam int RST_DLY     = 3;
    localparam int PSW_TIMEOUT = 8;

    localparam logic [2:0] ST_ON   = 3'd0;
    localparam logic [2:0] ST_ISO  = 3'd1;
    localparam logic [2:0] ST_SAVE = 3'd2;
    localparam logic [2:0] ST_OFF  = 3'd4;

    typedef struct {
        string      name;
        logic [2:0] end_state;
        logic       terr;
        int         busy_cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   sw_lat   = 1;
    bit   sw_stuck = 1'b0;
    bit   last_terr = 1'b0;
    bit   at_on     = 1'b0;

    always #5 clk = ~clk;

    pd_power_ctrl_if bus ();

    pd_power_ctrl #(
        .ISO_DLY    (ISO_DLY),
        .RST_DLY    (RST_DLY),
        .PSW_TIMEOUT(PSW_TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Domain control vector pwr_on/iso_en/dom_rst_n/save/restore for each state.
    function automatic logic [4:0] exp_vec(input logic [2:0] st);
        case (st)
            3'd0:    return 5'b10100;
            3'd1:    return 5'b11100;
            3'd2:    return 5'b11110;
            3'd3:    return 5'b01000;
            3'd4:    return 5'b01000;
            3'd5:    return 5'b11000;
            3'd6:    return 5'b11000;
            default: return 5'b11101;
        endcase
    endfunction

    function automatic bit is_idle(input logic [2:0] st);
        return (st == ST_ON) || (st == ST_OFF);
    endfunction

    // Busy time is the sum of the phase durations the sequence passes through.
    function automatic exp_t model_up(input int lat, input bit stuck, input string name);
        exp_t e;
        e.name = name;
        if (stuck) begin
            e.end_state   = ST_OFF;
            e.terr        = 1'b1;
            e.busy_cycles = PSW_TIMEOUT + 1;
        end else begin
            e.end_state   = ST_ON;
            e.terr        = 1'b0;
            e.busy_cycles = lat + RST_DLY + 1;
        end
        return e;
    endfunction

    function automatic exp_t model_down(input int lat, input bit stuck, input string name);
        exp_t e;
        e.name        = name;
        e.end_state   = ST_OFF;
        e.terr        = stuck;
        e.busy_cycles = ISO_DLY + 1 + (stuck ? PSW_TIMEOUT : lat);
        return e;
    endfunction

    // Power switch: the rail follows pwr_on after sw_lat cycles unless stuck.
    initial begin
        int sw_cnt;
        sw_cnt      = 0;
        bus.psw_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sw_stuck || bus.psw_ack == bus.pwr_on) begin
                sw_cnt = 0;
            end else begin
                sw_cnt++;
                if (sw_cnt >= sw_lat) begin
                    bus.psw_ack = bus.pwr_on;
                    sw_cnt      = 0;
                end
            end
        end
    end

    // Monitor: per-cycle output decode plus scoreboard pop on each done pulse.
    int         mon_cnt  = 0;
    logic [2:0] prev_st  = ST_OFF;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mon_cnt = 0;
            prev_st = ST_OFF;
        end else begin
            check("out_vec", {bus.pwr_on, bus.iso_en, bus.dom_rst_n, bus.save, bus.restore},
                  exp_vec(bus.state));
            check("busy", bus.busy, !is_idle(bus.state));
            check("done_rule", bus.done, is_idle(bus.state) && !is_idle(prev_st));
            if (bus.done) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check({e.name, "_end_state"}, bus.state, e.end_state);
                    check({e.name, "_timeout_err"}, bus.timeout_err, e.terr);
                    check({e.name, "_busy_cycles"}, mon_cnt, e.busy_cycles);
                end
                mon_cnt = 0;
            end else if (bus.busy) begin
                mon_cnt++;
            end
            prev_st = bus.state;
        end
    end

    task automatic pulse_req(input bit up, input string name);
        @(posedge clk);
        #1;
        check({name, "_terr_before"}, bus.timeout_err, last_terr);
        // NOTE: bench drives DUT inputs with blocking assignments, clear of the clock edge.
        if (up) bus.pwr_up_req = 1'b1;
        else    bus.pwr_down_req = 1'b1;
        @(posedge clk);
        #1;
        if (up) bus.pwr_up_req = 1'b0;
        else    bus.pwr_down_req = 1'b0;
        check({name, "_accepted"}, bus.busy, 1);
        check({name, "_terr_cleared"}, bus.timeout_err, 0);
    endtask

    // noise: 0 none, 1 toggle pwr_up_req, 2 toggle pwr_down_req while busy.
    task automatic wait_done(input string name, input int noise);
        bit seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            seen = bus.done;
            if (!seen && noise == 1) bus.pwr_up_req = 1'($urandom_range(0, 1));
            if (!seen && noise == 2) bus.pwr_down_req = 1'($urandom_range(0, 1));
        end
        if (noise == 1) bus.pwr_up_req = 1'b0;
        if (noise == 2) bus.pwr_down_req = 1'b0;
        check({name, "_done_seen"}, seen, 1);
    endtask

    task automatic settle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 32 && !ok; k++) begin
            @(negedge clk);
            ok = (bus.psw_ack == bus.pwr_on);
        end
        check({name, "_switch_settled"}, ok, 1);
    endtask

    task automatic do_txn(input bit up, input int lat, input bit stuck, input int noise,
                          input string name);
        exp_t e;
        e = up ? model_up(lat, stuck, name) : model_down(lat, stuck, name);
        sw_lat   = lat;
        sw_stuck = stuck;
        sb.push_back(e);
        pulse_req(up, name);
        wait_done(name, noise);
        sw_stuck  = 1'b0;
        last_terr = e.terr;
        at_on     = (e.end_state == ST_ON);
        settle(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bus.pwr_up_req   = 1'b0;
        bus.pwr_down_req = 1'b0;

        #12;
        check("rst_state", bus.state, ST_OFF);
        check("rst_vec", {bus.pwr_on, bus.iso_en, bus.dom_rst_n, bus.save, bus.restore}, 5'b01000);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_terr", bus.timeout_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", bus.state, ST_OFF);
        check("post_rst_done", bus.done, 0);

        do_txn(1'b1, 2, 1'b0, 0, "up_ack2");
        do_txn(1'b0, 1, 1'b0, 0, "down_ack1");
        do_txn(1'b1, 1, 1'b1, 0, "up_timeout");
        do_txn(1'b1, 1, 1'b0, 0, "up_after_to");

        // Both requests in ON, then an up pulse during ISO.
        sw_lat = 1;
        sb.push_back(model_down(1, 1'b0, "both_req"));
        @(posedge clk);
        #1;
        bus.pwr_up_req   = 1'b1;
        bus.pwr_down_req = 1'b1;
        @(posedge clk);
        #1;
        bus.pwr_up_req   = 1'b0;
        bus.pwr_down_req = 1'b0;
        check("both_req_iso", bus.state, ST_ISO);
        bus.pwr_up_req = 1'b1;
        @(posedge clk);
        #1;
        bus.pwr_up_req = 1'b0;
        check("iso_pulse_ignored", bus.state, ST_ISO);
        wait_done("both_req", 0);
        last_terr = 1'b0;
        at_on     = 1'b0;
        settle("both_req");

        // Back-to-back: pwr_down_req held across a full power-up.
        sw_lat = 1;
        bus.pwr_down_req = 1'b1;
        sb.push_back(model_up(1, 1'b0, "b2b_up"));
        pulse_req(1'b1, "b2b_up");
        wait_done("b2b_up", 0);
        sb.push_back(model_down(1, 1'b0, "b2b_down"));
        @(negedge clk);
        check("b2b_on_one_cycle", bus.state, ST_ISO);
        bus.pwr_down_req = 1'b0;
        wait_done("b2b_down", 0);
        last_terr = 1'b0;
        at_on     = 1'b0;
        settle("b2b_down");

        // Asynchronous reset while in SAVE.
        do_txn(1'b1, 1, 1'b0, 0, "up_pre_rst");
        sw_lat = 1;
        pulse_req(1'b0, "rst_mid");
        found = 1'b0;
        for (int k = 0; k < 16 && !found; k++) begin
            @(negedge clk);
            found = (bus.state == ST_SAVE);
        end
        check("rst_mid_reached_save", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", bus.state, ST_OFF);
        check("rst_mid_vec", {bus.pwr_on, bus.iso_en, bus.dom_rst_n, bus.save, bus.restore},
              5'b01000);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        @(posedge clk);
        #1;
        check("rst_mid_no_done", bus.done, 0);
        @(negedge clk);
        #2;
        rst_n     = 1'b1;
        last_terr = 1'b0;
        at_on     = 1'b0;
        settle("rst_mid");

        for (int i = 0; i < 40; i++) begin
            int lat;
            bit stuck;
            int noise;
            lat   = $urandom_range(1, PSW_TIMEOUT);
            stuck = ($urandom_range(0, 5) == 0);
            noise = ($urandom_range(0, 1) == 1) ? (at_on ? 2 : 1) : 0;
            do_txn(!at_on, lat, stuck, noise, at_on ? "rnd_down" : "rnd_up");
        end

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
